// File: rtl/mt_lifm_expander_pkg.sv
// Shared types, sizing helpers and the lowest-set-bit selector for the MT column expander.
// Optional MT_ROW_CHECK_EN build adds per-row multi-hit detection (see mt_row_select / mt_lifm_expander).
package mt_expander_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam int DEF_STEP_RANGE = 128;
  localparam int DEF_LANES      = 8;
  localparam int NUM_CHUNKS     = DEF_STEP_RANGE / DEF_LANES;
  localparam int CHUNK_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  // Rows are zero-extended to this width so one selector function serves every STEP_RANGE.
  localparam int MAX_STEP_RANGE = 512;
  localparam int IDX_W          = $clog2(MAX_STEP_RANGE);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } sel_t;

  function automatic int num_chunks(input int stepRange, input int lanes);
    return stepRange / lanes;
  endfunction

  function automatic int chunk_width(input int nChunks);
    return (nChunks > 1) ? $clog2(nChunks) : 1;
  endfunction

  function automatic sel_t lowest_set(input logic [MAX_STEP_RANGE-1:0] row);
    sel_t sel;
    sel.found = |row;
    sel.idx   = '0;
    for (int b = MAX_STEP_RANGE - 1; b >= 0; b--) begin
      if (row[b]) sel.idx = IDX_W'(b);
    end
    return sel;
  endfunction

endpackage

// File: rtl/mt_lifm_expander_if.sv
// Column handshake bundle between the dense-column buffer, the expander and the PE array.
interface mt_lifm_expander_if #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128
);

  logic                             in_valid;
  logic                             in_ready;
  logic [WORD_WIDTH*STEP_RANGE-1:0] dlifm_column;
  logic [STEP_RANGE*STEP_RANGE-1:0] mt_column;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column;
  logic                             mt_err;

  modport master (
    output in_valid, dlifm_column, mt_column, out_ready,
    input  in_ready, out_valid, lifm_column, mt_err
  );

  modport slave (
    input  in_valid, dlifm_column, mt_column, out_ready,
    output in_ready, out_valid, lifm_column, mt_err
  );

endinterface

// File: rtl/mt_lifm_expander_row_select.sv
// Resolves one output position: picks the dense word named by the lowest set bit of its MT row.
// With MT_ROW_CHECK_EN defined, also flags rows that name more than one dense word.
module mt_row_select
  import mt_expander_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128
) (
  input  logic [STEP_RANGE-1:0]            row_i,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_i,
`ifdef MT_ROW_CHECK_EN
  output logic                             multi_hit_o,
`endif
  output logic [WORD_WIDTH-1:0]            word_o
);

  logic [MAX_STEP_RANGE-1:0] rowExt;
  sel_t                      sel;

  always_comb begin
    rowExt                   = '0;
    rowExt[STEP_RANGE-1:0]   = row_i;
    sel                      = lowest_set(rowExt);
    word_o                   = '0;
    if (sel.found) word_o = dense_i[int'(sel.idx)*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef MT_ROW_CHECK_EN
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_hit_o = |(row_i & (row_i - {{(STEP_RANGE-1){1'b0}}, 1'b1}));
`endif

endmodule

// File: rtl/mt_lifm_expander.sv
// Rebuilds a full lowered IFM column from a dense column plus its mapping table, LANES words per cycle.
// Optional MT_ROW_CHECK_EN build reports MT rows with more than one bit set on mt_err.
module mt_lifm_expander
  import mt_expander_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int LANES      = 8
) (
  input logic               clk,
  input logic               reset,
  mt_lifm_expander_if.slave bus
);

  localparam int                    CHUNKS     = num_chunks(STEP_RANGE, LANES);
  localparam int                    CHUNK_BITS = chunk_width(CHUNKS);
  localparam logic [CHUNK_BITS-1:0] LAST_CHUNK = CHUNK_BITS'(CHUNKS - 1);

  if ((STEP_RANGE % LANES) != 0) begin : g_bad_lanes
    $error("mt_lifm_expander: LANES must divide STEP_RANGE");
  end
  if (STEP_RANGE > MAX_STEP_RANGE) begin : g_bad_range
    $error("mt_lifm_expander: STEP_RANGE exceeds MAX_STEP_RANGE");
  end

  state_e                           state_q, state_d;
  logic [CHUNK_BITS-1:0]            chunk_q, chunk_d;
  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_q, dense_d;
  logic [STEP_RANGE*STEP_RANGE-1:0] mt_q, mt_d;
  logic [WORD_WIDTH*STEP_RANGE-1:0] out_q, out_d;

  logic [STEP_RANGE-1:0] laneRow  [LANES];
  logic [WORD_WIDTH-1:0] laneWord [LANES];

`ifdef MT_ROW_CHECK_EN
  logic [LANES-1:0] laneHit;
  logic             err_q, err_d;
`endif

  // Each lane looks at the MT row for its position within the current chunk.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      laneRow[k] = mt_q[(int'(chunk_q)*LANES + k)*STEP_RANGE +: STEP_RANGE];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mt_row_select #(
      .WORD_WIDTH (WORD_WIDTH),
      .STEP_RANGE (STEP_RANGE)
    ) u_row_select (
      .row_i       (laneRow[k]),
      .dense_i     (dense_q),
`ifdef MT_ROW_CHECK_EN
      .multi_hit_o (laneHit[k]),
`endif
      .word_o      (laneWord[k])
    );
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    dense_d = dense_q;
    mt_d    = mt_q;
    out_d   = out_q;
`ifdef MT_ROW_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dense_d = bus.dlifm_column;
          mt_d    = bus.mt_column;
          out_d   = '0;
          chunk_d = '0;
`ifdef MT_ROW_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        for (int k = 0; k < LANES; k++) begin
          out_d[(int'(chunk_q)*LANES + k)*WORD_WIDTH +: WORD_WIDTH] = laneWord[k];
        end
`ifdef MT_ROW_CHECK_EN
        err_d = err_q | (|laneHit);
`endif
        // The counter parks on its last value; it is re-zeroed on the next capture.
        if (chunk_q == LAST_CHUNK) state_d = OUTPUT;
        else                       chunk_d = chunk_q + CHUNK_BITS'(1);
      end
      OUTPUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      chunk_q <= '0;
      dense_q <= '0;
      mt_q    <= '0;
      out_q   <= '0;
`ifdef MT_ROW_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      dense_q <= dense_d;
      mt_q    <= mt_d;
      out_q   <= out_d;
`ifdef MT_ROW_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // in_ready is masked while reset is held so a producer never sees a false ready.
  assign bus.in_ready    = (state_q == IDLE) && !reset;
  assign bus.out_valid   = (state_q == OUTPUT);
  assign bus.lifm_column = out_q;
`ifdef MT_ROW_CHECK_EN
  assign bus.mt_err      = err_q;
`else
  assign bus.mt_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mt_lifm_expander.sv
// Directed bench for mt_lifm_expander: one DUT with STEP_RANGE=8/LANES=2, one with STEP_RANGE=8/LANES=8.
module tb_mt_lifm_expander;

  logic clk;
  logic reset;

  int checkCount;
  int errorCount;

  // Row i of an MT occupies byte i; bit j of that byte selects dense word j.
  localparam logic [63:0] ID_DENSE  = 64'h0807_0605_0403_0201;
  localparam logic [63:0] ID_MT     = 64'h8040_2010_0804_0201;
  localparam logic [63:0] DUP_DENSE = 64'hEEDD_CCBB_9988_55AA;
  localparam logic [63:0] DUP_MT    = 64'h0000_0001_0201_0201;
  localparam logic [63:0] DUP_EXP   = 64'h0000_00AA_55AA_55AA;
  localparam logic [63:0] ERR_DENSE = 64'h0807_2204_0311_0201;
  localparam logic [63:0] ERR_MT    = 64'h8040_2010_2404_0201;
  localparam logic [63:0] ERR_EXP   = 64'h0807_2204_1111_0201;
  localparam logic [63:0] REV_MT    = 64'h0102_0408_1020_4080;
  localparam logic [63:0] REV_EXP   = 64'h0102_0304_0506_0708;
`ifdef MT_ROW_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  mt_lifm_expander_if #(.WORD_WIDTH(8), .STEP_RANGE(8)) busA ();
  mt_lifm_expander_if #(.WORD_WIDTH(8), .STEP_RANGE(8)) busB ();

  mt_lifm_expander #(.WORD_WIDTH(8), .STEP_RANGE(8), .LANES(2)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  mt_lifm_expander #(.WORD_WIDTH(8), .STEP_RANGE(8), .LANES(8)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] byteRev(input logic [63:0] v);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = v[(7-b)*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one column to DUT A for exactly one edge.
  task automatic applyStimulusA(input logic [63:0] dense, input logic [63:0] mt);
    busA.dlifm_column = dense;
    busA.mt_column    = mt;
    busA.in_valid     = 1'b1;
    tick();
    busA.in_valid     = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [63:0] dense, input logic [63:0] mt);
    busB.dlifm_column = dense;
    busB.mt_column    = mt;
    busB.in_valid     = 1'b1;
    tick();
    busB.in_valid     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checkCount++;
    if (busA.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset in_ready: got %b want 0", busA.in_ready); end
    checkCount++;
    if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset out_valid: got %b want 0", busA.out_valid); end
    checkCount++;
    if (busA.lifm_column !== 64'h0) begin errorCount++; $display("[TB] FAIL reset lifm: got %h want 0", busA.lifm_column); end
    checkCount++;
    if (busA.mt_err !== 1'b0) begin errorCount++; $display("[TB] FAIL reset mt_err: got %b want 0", busA.mt_err); end
    checkCount++;
    if (busB.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset B in_ready: got %b want 0", busB.in_ready); end
    reset = 1'b0;
    tick();
    checkCount++;
    if (busA.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL post-reset in_ready: got %b want 1", busA.in_ready); end
    checkCount++;
    if (busB.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL post-reset B in_ready: got %b want 1", busB.in_ready); end
  endtask

  task automatic test_identity();
    checkCount++;
    if (busA.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL identity in_ready: got %b want 1", busA.in_ready); end
    applyStimulusA(ID_DENSE, ID_MT);
    for (int c = 1; c <= 4; c++) begin
      checkCount++;
      if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL identity early out_valid c=%0d: got %b want 0", c, busA.out_valid); end
      checkCount++;
      if (busA.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL identity busy in_ready c=%0d: got %b want 0", c, busA.in_ready); end
      tick();
    end
    checkCount++;
    if (busA.out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL identity out_valid: got %b want 1", busA.out_valid); end
    checkCount++;
    if (busA.lifm_column !== ID_DENSE) begin errorCount++; $display("[TB] FAIL identity lifm: got %h want %h", busA.lifm_column, ID_DENSE); end
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
    checkCount++;
    if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL identity drain out_valid: got %b want 0", busA.out_valid); end
    checkCount++;
    if (busA.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL identity drain in_ready: got %b want 1", busA.in_ready); end
  endtask

  // out_ready is held high throughout to show it has no effect outside OUTPUT.
  task automatic test_duplication();
    busA.out_ready = 1'b1;
    tick();
    applyStimulusA(DUP_DENSE, DUP_MT);
    for (int c = 1; c <= 4; c++) begin
      checkCount++;
      if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL dup early out_valid c=%0d: got %b want 0", c, busA.out_valid); end
      tick();
    end
    checkCount++;
    if (busA.out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL dup out_valid: got %b want 1", busA.out_valid); end
    checkCount++;
    if (busA.lifm_column !== DUP_EXP) begin errorCount++; $display("[TB] FAIL dup lifm: got %h want %h", busA.lifm_column, DUP_EXP); end
    tick();
    busA.out_ready = 1'b0;
    checkCount++;
    if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL dup drain out_valid: got %b want 0", busA.out_valid); end
  endtask

  // A competing in_valid during OUTPUT must neither be accepted nor disturb the held column.
  task automatic test_backpressure();
    applyStimulusA(DUP_DENSE, DUP_MT);
    repeat (4) tick();
    busA.dlifm_column = ID_DENSE;
    busA.mt_column    = ID_MT;
    busA.in_valid     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkCount++;
      if (busA.out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp out_valid c=%0d: got %b want 1", c, busA.out_valid); end
      checkCount++;
      if (busA.lifm_column !== DUP_EXP) begin errorCount++; $display("[TB] FAIL bp lifm c=%0d: got %h want %h", c, busA.lifm_column, DUP_EXP); end
      checkCount++;
      if (busA.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL bp in_ready c=%0d: got %b want 0", c, busA.in_ready); end
      tick();
    end
    busA.in_valid  = 1'b0;
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
    checkCount++;
    if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp release out_valid: got %b want 0", busA.out_valid); end
    checkCount++;
    if (busA.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL bp release in_ready: got %b want 1", busA.in_ready); end
  endtask

  task automatic test_reset_mid();
    applyStimulusA(ID_DENSE, ID_MT);
    tick();
    reset = 1'b1;
    tick();
    checkCount++;
    if (busA.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset out_valid: got %b want 0", busA.out_valid); end
    checkCount++;
    if (busA.lifm_column !== 64'h0) begin errorCount++; $display("[TB] FAIL midreset lifm: got %h want 0", busA.lifm_column); end
    checkCount++;
    if (busA.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset in_ready: got %b want 0", busA.in_ready); end
    tick();
    checkCount++;
    if (busA.in_ready !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset held in_ready: got %b want 0", busA.in_ready); end
    reset = 1'b0;
    tick();
    test_identity();
  endtask

  task automatic test_mt_err();
    applyStimulusA(ERR_DENSE, ERR_MT);
    repeat (4) tick();
    checkCount++;
    if (busA.lifm_column !== ERR_EXP) begin errorCount++; $display("[TB] FAIL mterr lifm: got %h want %h", busA.lifm_column, ERR_EXP); end
    checkCount++;
    if (busA.mt_err !== EXP_ERR) begin errorCount++; $display("[TB] FAIL mterr flag: got %b want %b", busA.mt_err, EXP_ERR); end
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
    checkCount++;
    if (busA.mt_err !== EXP_ERR) begin errorCount++; $display("[TB] FAIL mterr sticky: got %b want %b", busA.mt_err, EXP_ERR); end
    applyStimulusA(ID_DENSE, ID_MT);
    checkCount++;
    if (busA.mt_err !== 1'b0) begin errorCount++; $display("[TB] FAIL mterr clear: got %b want 0", busA.mt_err); end
    repeat (4) tick();
    checkCount++;
    if (busA.lifm_column !== ID_DENSE) begin errorCount++; $display("[TB] FAIL mterr next lifm: got %h want %h", busA.lifm_column, ID_DENSE); end
    checkCount++;
    if (busA.mt_err !== 1'b0) begin errorCount++; $display("[TB] FAIL mterr next flag: got %b want 0", busA.mt_err); end
    busA.out_ready = 1'b1;
    tick();
    busA.out_ready = 1'b0;
  endtask

  task automatic test_full_lanes();
    checkCount++;
    if (busB.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL full in_ready: got %b want 1", busB.in_ready); end
    applyStimulusB(ID_DENSE, REV_MT);
    checkCount++;
    if (busB.out_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL full early out_valid: got %b want 0", busB.out_valid); end
    tick();
    checkCount++;
    if (busB.out_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL full out_valid: got %b want 1", busB.out_valid); end
    checkCount++;
    if (busB.lifm_column !== REV_EXP) begin errorCount++; $display("[TB] FAIL full lifm: got %h want %h", busB.lifm_column, REV_EXP); end
    busB.out_ready = 1'b1;
    tick();
    busB.out_ready = 1'b0;
    checkCount++;
    if (busB.in_ready !== 1'b1) begin errorCount++; $display("[TB] FAIL full drain in_ready: got %b want 1", busB.in_ready); end
  endtask

  // Producer holds in_valid with a fresh column after every accept; accepts land every 3 cycles.
  task automatic test_back_to_back();
    logic [63:0] colDense;
    logic        accepted;
    busB.out_ready    = 1'b1;
    busB.mt_column    = REV_MT;
    busB.dlifm_column = ID_DENSE;
    busB.in_valid     = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      checkCount++;
      if (busB.in_ready !== ((cyc % 3) == 0)) begin errorCount++; $display("[TB] FAIL b2b in_ready cyc=%0d: got %b want %b", cyc, busB.in_ready, ((cyc % 3) == 0)); end
      checkCount++;
      if (busB.out_valid !== ((cyc % 3) == 2)) begin errorCount++; $display("[TB] FAIL b2b out_valid cyc=%0d: got %b want %b", cyc, busB.out_valid, ((cyc % 3) == 2)); end
      if ((cyc % 3) == 2) begin
        colDense = ID_DENSE + 64'(cyc / 3) * 64'h1010_1010_1010_1010;
        checkCount++;
        if (busB.lifm_column !== byteRev(colDense)) begin errorCount++; $display("[TB] FAIL b2b lifm cyc=%0d: got %h want %h", cyc, busB.lifm_column, byteRev(colDense)); end
      end
      accepted = busB.in_ready;
      tick();
      if (accepted) busB.dlifm_column = ID_DENSE + 64'(cyc / 3 + 1) * 64'h1010_1010_1010_1010;
    end
    busB.in_valid  = 1'b0;
    busB.out_ready = 1'b0;
  endtask

  initial begin
    checkCount        = 0;
    errorCount        = 0;
    reset             = 1'b1;
    busA.in_valid     = 1'b0;
    busA.out_ready    = 1'b0;
    busA.dlifm_column = '0;
    busA.mt_column    = '0;
    busB.in_valid     = 1'b0;
    busB.out_ready    = 1'b0;
    busB.dlifm_column = '0;
    busB.mt_column    = '0;
    test_reset();
    test_identity();
    test_duplication();
    test_backpressure();
    test_reset_mid();
    test_mt_err();
    test_full_lanes();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
